// File: rtl/pb_conditioner.sv
// pb_conditioner
//   Conditions a raw, asynchronous, bouncing push button into clean
//   synchronous control signals: a debounced level, one-cycle press and
//   release pulses, and an auto-repeat pulse while the button is held.
//
// Parameters
//   DB_CYCLES     consecutive identical synchronized samples needed to accept
//                 a level change (>= 2)
//   HOLD_CYCLES   held cycles after the press pulse before the first repeat (>= 1)
//   REPEAT_CYCLES spacing of subsequent repeat pulses (>= 1)
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   pb            raw button, asynchronous to clk
//   pb_db         debounced level (registered)
//   press_pulse   one-cycle pulse on an accepted press (registered)
//   release_pulse one-cycle pulse on an accepted release (registered)
//   repeat_pulse  one-cycle auto-repeat pulse while held (registered)
module pb_conditioner #(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic pb_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HR_W   = $clog2(HR_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [HR_W-1:0] HOLD_LAST   = HR_W'(HOLD_CYCLES - 1);
    localparam logic [HR_W-1:0] REPEAT_LAST = HR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              sync1, pb_s;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HR_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              first_q, first_d;
    logic              pb_db_d, press_d, release_d, repeat_d;
    logic              hold_adv;
    logic              hold_hit;

    // Two-flop synchronizer; only pb_s is seen by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            pb_s  <= 1'b0;
        end else begin
            sync1 <= pb;
            pb_s  <= sync1;
        end
    end

    // The hold counter fires one cycle before it would reach the target so
    // that the registered pulse lands exactly HOLD/REPEAT cycles apart.
    assign hold_hit = (hold_cnt_q == (first_q ? HOLD_LAST : REPEAT_LAST));

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        first_d    = first_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        repeat_d   = 1'b0;
        hold_adv   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pb_s) begin
                    db_cnt_d = DB_W'(1);
                    state_d  = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!pb_s) begin
                    db_cnt_d = '0;
                    state_d  = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                    first_d    = 1'b1;
                    press_d    = 1'b1;
                    state_d    = PRESSED;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            PRESSED: begin
                if (pb_s) begin
                    hold_adv = 1'b1;
                end else begin
                    db_cnt_d = DB_W'(1);
                    state_d  = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                // Hold counter is frozen on low samples; the high sample that
                // cancels the release is itself a held cycle and counts.
                if (pb_s) begin
                    db_cnt_d = '0;
                    hold_adv = 1'b1;
                    state_d  = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    db_cnt_d  = '0;
                    release_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                db_cnt_d = '0;
                state_d  = IDLE;
            end
        endcase

        if (hold_adv) begin
            if (hold_hit) begin
                hold_cnt_d = '0;
                first_d    = 1'b0;
                repeat_d   = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HR_W'(1);
            end
        end

        pb_db_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            db_cnt_q      <= '0;
            hold_cnt_q    <= '0;
            first_q       <= 1'b0;
            pb_db         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            first_q       <= first_d;
            pb_db         <= pb_db_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            repeat_pulse  <= repeat_d;
        end
    end

endmodule
